// File: rtl/lif_stdp_pkg.sv
// Shared constants and saturating arithmetic helpers for the LIF/STDP neuron.
// Helpers operate on 32-bit operands; callers size-cast results back to their register width.
package lif_stdp_pkg;

  localparam int unsigned DEF_N_IN     = 4;
  localparam int unsigned DEF_W_W      = 6;
  localparam int unsigned DEF_V_W      = 8;
  localparam int unsigned DEF_V_TH     = 128;
  localparam int unsigned DEF_LEAK_SH  = 3;
  localparam int unsigned DEF_REFRAC   = 4;
  localparam int unsigned DEF_TRACE_W  = 3;
  localparam int unsigned DEF_W_INIT   = 16;
  localparam int unsigned DEF_LTP_STEP = 2;
  localparam int unsigned DEF_LTD_STEP = 1;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  // A spike reloads the trace to full scale; otherwise it decays by one toward zero.
  function automatic logic [31:0] trace_next(input logic        spk,
                                             input logic [31:0] trace,
                                             input logic [31:0] t_max);
    if (spk) return t_max;
    return (trace != 32'd0) ? (trace - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One plastic synapse: weight register, presynaptic trace and pair-based LTP/LTD update.
module stdp_synapse
  import lif_stdp_pkg::*;
#(
  parameter int unsigned W_W      = DEF_W_W,
  parameter int unsigned TRACE_W  = DEF_TRACE_W,
  parameter int unsigned W_INIT   = DEF_W_INIT,
  parameter int unsigned LTP_STEP = DEF_LTP_STEP,
  parameter int unsigned LTD_STEP = DEF_LTD_STEP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           learn_en,
  input  logic           pre_spk,
  input  logic           fire,
  input  logic           post_trace_nz,
  output logic [W_W-1:0] w
);

  localparam logic [31:0] W_MAX = (32'd1 << W_W) - 32'd1;
  localparam logic [31:0] T_MAX = (32'd1 << TRACE_W) - 32'd1;

  logic [TRACE_W-1:0] pre_trace;
  logic [TRACE_W-1:0] pre_trace_d;
  logic [W_W-1:0]     w_d;
  logic               ltp;
  logic               ltd;

  // A coincident pre and post spike is causal, so LTP takes priority over LTD.
  always_comb begin
    ltp         = learn_en && fire && (pre_spk || (pre_trace != '0));
    ltd         = learn_en && !fire && pre_spk && post_trace_nz;
    w_d         = w;
    if (ltp)
      w_d = W_W'(sat_add(32'(w), LTP_STEP, W_MAX));
    else if (ltd)
      w_d = W_W'(sat_sub(32'(w), LTD_STEP));
    pre_trace_d = TRACE_W'(trace_next(pre_spk, 32'(pre_trace), T_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w         <= W_W'(W_INIT);
      pre_trace <= '0;
    end else if (en) begin
      w         <= w_d;
      pre_trace <= pre_trace_d;
    end
  end

endmodule

// File: rtl/lif_stdp_neuron_n.sv
// Leaky integrate-and-fire neuron with N_IN plastic STDP synapses, bias current and refractory period.
// Membrane, refractory counter, post trace and current summation live here; weights live in the synapses.
module lif_stdp_neuron_n
  import lif_stdp_pkg::*;
#(
  parameter int unsigned N_IN     = DEF_N_IN,
  parameter int unsigned W_W      = DEF_W_W,
  parameter int unsigned V_W      = DEF_V_W,
  parameter int unsigned V_TH     = DEF_V_TH,
  parameter int unsigned LEAK_SH  = DEF_LEAK_SH,
  parameter int unsigned REFRAC   = DEF_REFRAC,
  parameter int unsigned TRACE_W  = DEF_TRACE_W,
  parameter int unsigned W_INIT   = DEF_W_INIT,
  parameter int unsigned LTP_STEP = DEF_LTP_STEP,
  parameter int unsigned LTD_STEP = DEF_LTD_STEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  learn_en,
  input  logic [N_IN-1:0]       pre_spk,
  input  logic [V_W-1:0]        ext_cur,
  output logic                  post_spk,
  output logic [V_W-1:0]        v_mem,
  output logic                  refrac,
  output logic [N_IN*W_W-1:0]   w_flat
);

  localparam int unsigned I_W  = ((V_W > W_W) ? V_W : W_W) + $clog2(N_IN) + 1;
  localparam int unsigned S_W  = I_W + 1;
  localparam int unsigned RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [S_W-1:0]  V_MAX_S = S_W'((64'd1 << V_W) - 64'd1);
  localparam logic [S_W-1:0]  V_TH_S  = S_W'(V_TH);
  localparam logic [31:0]     T_MAX   = (32'd1 << TRACE_W) - 32'd1;

  logic [W_W-1:0]     w_arr [N_IN];
  logic [I_W-1:0]     cur;
  logic [V_W-1:0]     v_leaked;
  logic [S_W-1:0]     v_sum;
  logic [V_W-1:0]     v_sat;
  logic               fire;
  logic               refractory;
  logic [RC_W-1:0]    rc;
  logic [TRACE_W-1:0] post_trace;
  logic               post_trace_nz;

  assign refractory    = (rc != '0);
  assign refrac        = refractory;
  assign post_trace_nz = (post_trace != '0);

  // Summation is wide enough that the bias plus every weight can never wrap.
  always_comb begin
    cur = I_W'(ext_cur);
    for (int i = 0; i < N_IN; i++) begin
      if (pre_spk[i]) cur = cur + I_W'(w_arr[i]);
    end
  end

  always_comb begin
    v_leaked = v_mem - (v_mem >> LEAK_SH);
    v_sum    = S_W'(v_leaked) + S_W'(cur);
    v_sat    = (v_sum > V_MAX_S) ? V_W'(V_MAX_S) : V_W'(v_sum);
    fire     = !refractory && (S_W'(v_sat) >= V_TH_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_mem      <= '0;
      rc         <= '0;
      post_trace <= '0;
      post_spk   <= 1'b0;
    end else if (!en) begin
      post_spk <= 1'b0;
    end else begin
      post_spk   <= fire;
      post_trace <= TRACE_W'(trace_next(fire, 32'(post_trace), T_MAX));
      if (refractory) begin
        v_mem <= '0;
        rc    <= rc - RC_W'(1);
      end else if (fire) begin
        v_mem <= '0;
        rc    <= RC_W'(REFRAC);
      end else begin
        v_mem <= v_sat;
      end
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_syn
    stdp_synapse #(
      .W_W      (W_W),
      .TRACE_W  (TRACE_W),
      .W_INIT   (W_INIT),
      .LTP_STEP (LTP_STEP),
      .LTD_STEP (LTD_STEP)
    ) u_syn (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .learn_en      (learn_en),
      .pre_spk       (pre_spk[i]),
      .fire          (fire),
      .post_trace_nz (post_trace_nz),
      .w             (w_arr[i])
    );
    assign w_flat[i*W_W +: W_W] = w_arr[i];
  end

endmodule

// File: tb/tb_lif_stdp_neuron_n.sv
// Self-checking bench for lif_stdp_neuron_n: vector table, directed STDP corner cases,
// and randomized stimulus compared against an arithmetic reference model.
module tb_lif_stdp_neuron_n;

  localparam int N_IN = 4, W_W = 6, V_W = 8, V_TH = 128, LEAK_SH = 3, REFRAC = 4;
  localparam int TRACE_W = 3, W_INIT = 16, LTP_STEP = 2, LTD_STEP = 1;
  localparam int W_MAX = (1 << W_W) - 1, V_MAX = (1 << V_W) - 1, T_MAX = (1 << TRACE_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                learn_en = 1'b0;
  logic [N_IN-1:0]     pre_spk = '0;
  logic [V_W-1:0]      ext_cur = '0;
  logic                post_spk;
  logic [V_W-1:0]      v_mem;
  logic                refrac;
  logic [N_IN*W_W-1:0] w_flat;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_v, m_rc, m_pt, m_post;
  int m_w  [N_IN];
  int m_tr [N_IN];

  typedef struct {
    logic [N_IN-1:0] pre;
    logic [V_W-1:0]  cur;
    int              exp_v;
    int              exp_post;
    int              exp_ref;
  } vec_t;

  vec_t vecs [12];

  lif_stdp_neuron_n #(
    .N_IN(N_IN), .W_W(W_W), .V_W(V_W), .V_TH(V_TH), .LEAK_SH(LEAK_SH), .REFRAC(REFRAC),
    .TRACE_W(TRACE_W), .W_INIT(W_INIT), .LTP_STEP(LTP_STEP), .LTD_STEP(LTD_STEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .learn_en (learn_en),
    .pre_spk  (pre_spk),
    .ext_cur  (ext_cur),
    .post_spk (post_spk),
    .v_mem    (v_mem),
    .refrac   (refrac),
    .w_flat   (w_flat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int dut_w(input int i);
    return int'(w_flat[i*W_W +: W_W]);
  endfunction

  task automatic model_reset();
    m_v = 0; m_rc = 0; m_pt = 0; m_post = 0;
    for (int i = 0; i < N_IN; i++) begin
      m_w[i]  = W_INIT;
      m_tr[i] = 0;
    end
  endtask

  task automatic model_step(input logic e, input logic l, input logic [N_IN-1:0] p, input int c);
    int cur, vn, rcn;
    bit fire;
    if (!e) begin
      m_post = 0;
      return;
    end
    cur = c;
    for (int i = 0; i < N_IN; i++) if (p[i]) cur += m_w[i];
    fire = 0;
    if (m_rc > 0) begin
      vn  = 0;
      rcn = m_rc - 1;
    end else begin
      vn = m_v - m_v / (1 << LEAK_SH) + cur;
      if (vn > V_MAX) vn = V_MAX;
      if (vn >= V_TH) begin
        fire = 1; vn = 0; rcn = REFRAC;
      end else begin
        rcn = 0;
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (l) begin
        if (fire && (p[i] || m_tr[i] > 0))
          m_w[i] = (m_w[i] + LTP_STEP > W_MAX) ? W_MAX : m_w[i] + LTP_STEP;
        else if (!fire && p[i] && m_pt > 0)
          m_w[i] = (m_w[i] < LTD_STEP) ? 0 : m_w[i] - LTD_STEP;
      end
      m_tr[i] = p[i] ? T_MAX : ((m_tr[i] > 0) ? m_tr[i] - 1 : 0);
    end
    m_pt   = fire ? T_MAX : ((m_pt > 0) ? m_pt - 1 : 0);
    m_v    = vn;
    m_rc   = rcn;
    m_post = fire;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " v_mem"}, int'(v_mem), m_v);
    checkOutput({tag, " post_spk"}, int'(post_spk), m_post);
    checkOutput({tag, " refrac"}, int'(refrac), (m_rc != 0) ? 1 : 0);
    for (int i = 0; i < N_IN; i++)
      checkOutput($sformatf("%s w[%0d]", tag, i), dut_w(i), m_w[i]);
  endtask

  task automatic applyStimulus(input logic e, input logic l, input logic [N_IN-1:0] p, input int c);
    en = e; learn_en = l; pre_spk = p; ext_cur = V_W'(c);
    @(posedge clk);
    #1;
    model_step(e, l, p, c);
  endtask

  task automatic doReset();
    en = 1'b0; learn_en = 1'b0; pre_spk = '0; ext_cur = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int edges;
    logic [N_IN-1:0] p;
    int c;

    // Reset held across clock edges
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset v_mem", int'(v_mem), 0);
    checkOutput("reset post_spk", int'(post_spk), 0);
    checkOutput("reset refrac", int'(refrac), 0);
    for (int i = 0; i < N_IN; i++) checkOutput($sformatf("reset w[%0d]", i), dut_w(i), W_INIT);
    rst_n = 1'b1;

    // Leak / fire / refractory trajectory with ext_cur=40
    vecs[0]  = '{pre: '0, cur: 8'd40, exp_v: 40,  exp_post: 0, exp_ref: 0};
    vecs[1]  = '{pre: '0, cur: 8'd40, exp_v: 75,  exp_post: 0, exp_ref: 0};
    vecs[2]  = '{pre: '0, cur: 8'd40, exp_v: 106, exp_post: 0, exp_ref: 0};
    vecs[3]  = '{pre: '0, cur: 8'd40, exp_v: 0,   exp_post: 1, exp_ref: 1};
    vecs[4]  = '{pre: '0, cur: 8'd40, exp_v: 0,   exp_post: 0, exp_ref: 1};
    vecs[5]  = '{pre: '0, cur: 8'd40, exp_v: 0,   exp_post: 0, exp_ref: 1};
    vecs[6]  = '{pre: '0, cur: 8'd40, exp_v: 0,   exp_post: 0, exp_ref: 1};
    vecs[7]  = '{pre: '0, cur: 8'd40, exp_v: 0,   exp_post: 0, exp_ref: 0};
    vecs[8]  = '{pre: '0, cur: 8'd40, exp_v: 40,  exp_post: 0, exp_ref: 0};
    vecs[9]  = '{pre: '0, cur: 8'd40, exp_v: 75,  exp_post: 0, exp_ref: 0};
    vecs[10] = '{pre: '0, cur: 8'd40, exp_v: 106, exp_post: 0, exp_ref: 0};
    vecs[11] = '{pre: '0, cur: 8'd40, exp_v: 0,   exp_post: 1, exp_ref: 1};
    doReset();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, vecs[k].pre, int'(vecs[k].cur));
      checkOutput($sformatf("vec%0d v_mem", k), int'(v_mem), vecs[k].exp_v);
      checkOutput($sformatf("vec%0d post_spk", k), int'(post_spk), vecs[k].exp_post);
      checkOutput($sformatf("vec%0d refrac", k), int'(refrac), vecs[k].exp_ref);
    end

    // LTP: pre spike on synapse 0 followed by a post spike
    doReset();
    applyStimulus(1'b1, 1'b1, 4'b0001, 40);
    checkModel("ltp");
    edges = 1;
    while (!post_spk && edges < 8) begin
      applyStimulus(1'b1, 1'b1, 4'b0000, 40);
      checkModel("ltp");
      edges++;
    end
    checkOutput("ltp fire edge", edges, 4);
    checkOutput("ltp w[0]", dut_w(0), 18);
    for (int i = 1; i < N_IN; i++) checkOutput($sformatf("ltp w[%0d]", i), dut_w(i), 16);

    // LTD: pre spike on synapse 1 two cycles after the post spike
    applyStimulus(1'b1, 1'b1, 4'b0000, 0);
    checkModel("ltd");
    applyStimulus(1'b1, 1'b1, 4'b0010, 0);
    checkModel("ltd");
    checkOutput("ltd w[0]", dut_w(0), 18);
    checkOutput("ltd w[1]", dut_w(1), 15);
    checkOutput("ltd w[2]", dut_w(2), 16);
    checkOutput("ltd w[3]", dut_w(3), 16);
    checkOutput("ltd v_mem", int'(v_mem), 0);
    checkOutput("ltd refrac", int'(refrac), 1);

    // Asynchronous reset mid-refractory, no clock edge involved
    rst_n = 1'b0;
    #2;
    checkOutput("async reset v_mem", int'(v_mem), 0);
    checkOutput("async reset post_spk", int'(post_spk), 0);
    checkOutput("async reset refrac", int'(refrac), 0);
    for (int i = 0; i < N_IN; i++) checkOutput($sformatf("async reset w[%0d]", i), dut_w(i), W_INIT);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Weight saturation high: 30 LTP pairings with a saturating bias
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b1, 1'b1, 4'b0001, 255);
      checkModel("satltp");
      if (k == 0) begin
        checkOutput("sat v fire post_spk", int'(post_spk), 1);
        checkOutput("sat v fire v_mem", int'(v_mem), 0);
      end
      repeat (REFRAC) begin
        applyStimulus(1'b1, 1'b1, 4'b0000, 0);
        checkModel("satltp");
      end
    end
    checkOutput("sat ltp w[0]", dut_w(0), W_MAX);

    // Weight saturation low: 20 LTD pairings on synapse 2
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1, 4'b0000, 255);
      checkModel("satltd");
      applyStimulus(1'b1, 1'b1, 4'b0100, 0);
      checkModel("satltd");
      repeat (8) begin
        applyStimulus(1'b1, 1'b1, 4'b0000, 0);
        checkModel("satltd");
      end
    end
    checkOutput("sat ltd w[2]", dut_w(2), 0);

    // Learning frozen: same LTP scenario leaves weights at reset value
    doReset();
    applyStimulus(1'b1, 1'b0, 4'b0001, 40);
    edges = 1;
    while (!post_spk && edges < 8) begin
      applyStimulus(1'b1, 1'b0, 4'b0000, 40);
      edges++;
    end
    checkOutput("freeze fire edge", edges, 4);
    for (int i = 0; i < N_IN; i++) checkOutput($sformatf("freeze w[%0d]", i), dut_w(i), W_INIT);
    repeat (REFRAC) applyStimulus(1'b1, 1'b0, 4'b0000, 0);
    applyStimulus(1'b1, 1'b0, 4'b0010, 0);
    checkOutput("freeze no ltd w[1]", dut_w(1), W_INIT);
    // Trace loaded while frozen must still drive LTP once learning resumes
    applyStimulus(1'b1, 1'b1, 4'b0000, 255);
    checkOutput("frozen trace post_spk", int'(post_spk), 1);
    checkOutput("frozen trace w[1]", dut_w(1), W_INIT + LTP_STEP);
    checkModel("freeze");

    // Enable low holds all state and forces post_spk low
    repeat (REFRAC) applyStimulus(1'b1, 1'b1, 4'b0000, 0);
    applyStimulus(1'b1, 1'b1, 4'b0000, 40);
    checkOutput("pre-hold v_mem", int'(v_mem), 40);
    repeat (3) begin
      applyStimulus(1'b0, 1'b1, 4'b1111, 255);
      checkOutput("en0 v_mem", int'(v_mem), 40);
      checkOutput("en0 post_spk", int'(post_spk), 0);
      checkModel("en0");
    end
    applyStimulus(1'b1, 1'b1, 4'b0000, 255);
    checkOutput("en1 fire post_spk", int'(post_spk), 1);
    checkModel("en1");
    repeat (3) begin
      applyStimulus(1'b0, 1'b1, 4'b1111, 255);
      checkOutput("en0 hold post_spk", int'(post_spk), 0);
      checkOutput("en0 hold refrac", int'(refrac), 1);
      checkModel("en0hold");
    end

    // Randomized stimulus against the reference model
    doReset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N_IN; i++) p[i] = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 50));
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, p, c);
      checkModel("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_stdp_neuron_n.md
# lif_stdp_neuron_n

Parametrised leaky integrate-and-fire neuron with N plastic input synapses and on-chip pair-based STDP. It is the successor to the fixed two-neuron/one-synapse core: any number of presynaptic spike inputs, a bias current, configurable widths, a refractory period and a learn/freeze mode. Instances sit behind the tile's I/O mux; layers are built by chaining `post_spk` into other instances' `pre_spk`.

## Interface
- `N_IN`, 4: number of presynaptic inputs/synapses
- `W_W`, 6: weight width; W_MAX = 2^W_W-1
- `V_W`, 8: membrane potential width; V_MAX = 2^V_W-1
- `V_TH`, 128: firing threshold (compare is >=)
- `LEAK_SH`, 3: leak = v >> LEAK_SH per cycle
- `REFRAC`, 4: refractory cycles after a spike
- `TRACE_W`, 3: STDP trace width; T_MAX = 2^TRACE_W-1
- `W_INIT`, 16: weight reset value
- `LTP_STEP`, 2 / `LTD_STEP`, 1: potentiation / depression increments
---
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `en` in 1: advance neuron state; 0 freezes all state
- `learn_en` in 1: 1 enables weight updates; traces update regardless
- `pre_spk` in N_IN: presynaptic spikes, one bit per synapse, sampled each edge
- `ext_cur` in V_W: unsigned bias current added every cycle
- `post_spk` out 1: registered one-cycle spike pulse
- `v_mem` out V_W: membrane potential register
- `refrac` out 1: high while refractory counter != 0
- `w_flat` out N_IN*W_W: weights, synapse i at [i*W_W +: W_W]

## Operation
- Reset (async): v_mem=0, all weights=W_INIT, all pre traces=0, post trace=0, refractory count=0, post_spk=0, refrac=0.
- en=0: every register holds; post_spk forced 0 at next edge.
- Input current I = ext_cur + sum of w[i] where pre_spk[i]=1; computed at full width (V_W + clog2(N_IN)+1 bits min), no wrap.
- Not refractory: v_next = v - (v>>LEAK_SH) + I, saturated to V_MAX. If v_next >= V_TH: fire -> v_mem=0, post_spk=1, refractory count=REFRAC. Else v_mem=v_next, post_spk=0.
- Refractory (count != 0): v_mem held 0, I ignored, count decrements, no firing.
- Pre trace i: pre_spk[i] -> T_MAX, else decrement saturating at 0. Post trace: fire -> T_MAX, else saturating decrement.
- LTP (learn_en, fire this cycle): for each i with pre_spk[i]=1 or pre_trace[i]!=0: w[i] += LTP_STEP, saturate W_MAX.
- LTD (learn_en, no fire this cycle): for each i with pre_spk[i]=1 and registered post_trace!=0: w[i] -= LTD_STEP, saturate 0.
- Simultaneous pre and post in one cycle counts as causal: LTP only. LTD applies during refractory too.
- Traces and LTD/LTP use pre-edge register values; all updates commit at the same edge.

## Timing
- Latency pre_spk/ext_cur -> post_spk: 1 edge (combinational integrate, registered result).
- Weight change visible on w_flat at the same edge as the causing post_spk or pre_spk sample; used for I from the following cycle.
- Minimum inter-spike interval: REFRAC+1 cycles.
- rst_n deassertion is synchronous to downstream use; first active edge integrates from v=0.

## Structure
- Package `lif_stdp_pkg`: saturating add/sub functions (width-generic), trace update function, default parameter constants.
- Sub-module `stdp_synapse` (generated N_IN times): one weight register, one pre trace, LTP/LTD logic; inputs pre_spk bit, fire, post_trace_nz, learn_en, en. Top holds membrane, refractory counter, post trace, current adder tree.

## Test plan
- Reset: hold rst_n=0, toggle clk -> v_mem=0, w_flat=all 16, post_spk=0; assert rst_n mid-refractory without clk edge -> outputs return to reset values immediately.
- Leak/fire: ext_cur=40, pre_spk=0 -> v_mem 40, 75, 106, then post_spk=1 and v_mem=0 at edge 4; refrac high edges 4-7, v_mem=40 at edge 9; spike period 8 cycles.
- LTP: learn_en=1, pre_spk[0] pulse + ext_cur=40 same cycle -> fire within 4 edges, w[0]=18, w[1..3]=16.
- LTD: force fire, ext_cur=0, pre_spk[1] pulse 2 cycles later -> w[1]=15, others unchanged, v_mem stays 0 (refractory).
- Saturation: 30 LTP pairings -> w[0]=63 (no wrap); 20 LTD pairings from 16 -> 0; ext_cur=255 -> v_next saturates, fires, v_mem=0.
- Freeze: learn_en=0 repeat LTP scenario -> weights stay 16, traces still load 7; en=0 -> v_mem, weights, counters hold, post_spk=0.
